// File: rtl/drive_dac_interface.sv
// DAC output stage: converts I/Q sums to offset-binary DAC codes, buffers them in a
// prefilled elastic FIFO and streams gap-free bursts. `DRIVE_DAC_SAT_EN selects clip vs wrap.
module drive_dac_interface #(
  parameter int IQ_SUM_WIDTH    = 14,
  parameter int DAC_WIDTH       = 10,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PREFILL_LEVEL   = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic signed [IQ_SUM_WIDTH-1:0] i_in,
  input  logic signed [IQ_SUM_WIDTH-1:0] q_in,
  input  logic                           clear_flags,
  output logic                           dac_valid,
  output logic [DAC_WIDTH-1:0]           dac_i,
  output logic [DAC_WIDTH-1:0]           dac_q,
  output logic                           burst_done,
  output logic                           overflow,
  output logic                           underflow,
  output logic [FIFO_ADDR_WIDTH:0]       fifo_level,
  output logic [CNT_WIDTH-1:0]           sample_count
);

  typedef enum logic [1:0] {IDLE, PREFILL, STREAM} state_t;

  localparam int                   LW        = FIFO_ADDR_WIDTH + 1;
  localparam logic [DAC_WIDTH-1:0] MID       = {1'b1, {(DAC_WIDTH-1){1'b0}}};
  localparam logic [LW-1:0]        DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]        PREFILL_L = LW'(PREFILL_LEVEL);

  function automatic logic [DAC_WIDTH-1:0] to_dac(input logic signed [IQ_SUM_WIDTH-1:0] v);
    logic [DAC_WIDTH-1:0] r;
`ifdef DRIVE_DAC_SAT_EN
    logic signed [IQ_SUM_WIDTH-1:0] max_v;
    logic signed [IQ_SUM_WIDTH-1:0] min_v;
    max_v = $signed({{(IQ_SUM_WIDTH-DAC_WIDTH+1){1'b0}}, {(DAC_WIDTH-1){1'b1}}});
    min_v = ~max_v;
    if (v > max_v)      r = DAC_WIDTH'(max_v);
    else if (v < min_v) r = DAC_WIDTH'(min_v);
    else                r = DAC_WIDTH'(v);
`else
    r = DAC_WIDTH'(v);
`endif
    return {~r[DAC_WIDTH-1], r[DAC_WIDTH-2:0]};
  endfunction

  state_t                     state_q, state_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       dac_valid_q, dac_valid_d;
  logic [DAC_WIDTH-1:0]       dac_i_q, dac_i_d;
  logic [DAC_WIDTH-1:0]       dac_q_q, dac_q_d;
  logic                       burst_done_q, burst_done_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;
  logic [CNT_WIDTH-1:0]       count_q, count_d;

  logic                       pop, full, wr_en, ovf_set, unf_set;
  logic [2*DAC_WIDTH-1:0]     head;
  logic [2*DAC_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];

  // Storage carries no reset; pointers and level alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= {to_dac(i_in), to_dac(q_in)};
  end

  assign head = fifo_mem[rd_ptr_q];

  always_comb begin
    pop          = (state_q == STREAM) && (level_q != '0);
    full         = (level_q == DEPTH_L);
    wr_en        = valid_in && (!full || pop);
    ovf_set      = valid_in && full && !pop;
    unf_set      = 1'b0;
    state_d      = state_q;
    burst_done_d = 1'b0;

    case (state_q)
      IDLE:    if (wr_en) state_d = PREFILL;
      PREFILL: if ((level_q >= PREFILL_L) || (!valid_in && level_q != '0)) state_d = STREAM;
      STREAM: begin
        // Empty in STREAM means no pop this cycle; the burst ends here either way.
        if (level_q == '0) begin
          state_d      = IDLE;
          burst_done_d = 1'b1;
          unf_set      = valid_in;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    dac_valid_d = pop;
    dac_i_d     = pop ? head[2*DAC_WIDTH-1:DAC_WIDTH] : MID;
    dac_q_d     = pop ? head[DAC_WIDTH-1:0]           : MID;
    count_d     = (pop && count_q != '1) ? count_q + 1'b1 : count_q;

    // Set has priority over clear.
    overflow_d  = ovf_set ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
    underflow_d = unf_set ? 1'b1 : (clear_flags ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dac_valid_q  <= 1'b0;
      dac_i_q      <= MID;
      dac_q_q      <= MID;
      burst_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dac_valid_q  <= dac_valid_d;
      dac_i_q      <= dac_i_d;
      dac_q_q      <= dac_q_d;
      burst_done_q <= burst_done_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      count_q      <= count_d;
    end
  end

  assign dac_valid    = dac_valid_q;
  assign dac_i        = dac_i_q;
  assign dac_q        = dac_q_q;
  assign burst_done   = burst_done_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign fifo_level   = level_q;
  assign sample_count = count_q;

endmodule
